// File: rtl/cic_decimator.sv
// cic_decimator: runtime-rate CIC decimation filter (R = 2^k) with round-half-up
// output scaling, extra gain shift, saturation and warm-up strobe gating.
module cic_decimator #(
   parameter int DATA_WIDTH    = 16,
   parameter int STAGES        = 4,
   parameter int MAX_RATE_LOG2 = 6,
   parameter int DIFF_DELAY    = 1
) (
   input  logic                  i_clk,
   input  logic                  i_resetn,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic [2:0]            i_rate_log2,
   input  logic [2:0]            i_gain_shift,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_sat
);
   localparam int ACC_W = DATA_WIDTH + STAGES*(MAX_RATE_LOG2 + DIFF_DELAY - 1);
   localparam int OUT_W = ACC_W + 9;
   localparam int WARM  = STAGES*DIFF_DELAY;
   localparam int WU_W  = $clog2(WARM + 1);
   localparam logic signed [OUT_W-1:0] ONE = 1;

   logic [ACC_W-1:0]         int_q [STAGES], int_d [STAGES];
   logic [ACC_W-1:0]         cb_q [STAGES], cb_d [STAGES], cin [STAGES];
   logic [ACC_W-1:0]         d1_q [STAGES], d1_d [STAGES], d2_q [STAGES], d2_d [STAGES];
   logic [7:0]               sh_q [STAGES+1], sh_d [STAGES+1];
   logic [STAGES:0]          tv_q, tv_d, gd_q, gd_d;
   logic [MAX_RATE_LOG2-1:0] cnt_q, cnt_d;
   logic [2:0]               k_q, k_d, g_q, g_d, k_in;
   logic [WU_W-1:0]          wu_q, wu_d;
   logic                     started_q, started_d, wrap, sat;
   logic signed [OUT_W-1:0]  xe, y;
   logic signed [7:0]        sh;
   logic [DATA_WIDTH-1:0]    o_data_q, o_data_d;
   logic                     o_valid_q, o_valid_d, o_sat_q, o_sat_d;

   always_comb begin
      k_in = (i_rate_log2 == 3'd0) ? 3'd1 :
             (int'(i_rate_log2) > MAX_RATE_LOG2) ? 3'(MAX_RATE_LOG2) : i_rate_log2;
      wrap = i_valid && started_q && (int'(cnt_q) == (1 << k_q) - 1);
      started_d = 1'b1;
      k_d = (!started_q || wrap) ? k_in : k_q;
      g_d = (!started_q || wrap) ? i_gain_shift : g_q;
      cnt_d = !i_valid ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
      // The token leaving at a k change still belongs to the old period, so it is judged on the old count.
      wu_d = !wrap ? wu_q : (k_in != k_q) ? '0 : (int'(wu_q) < WARM) ? wu_q + 1'b1 : wu_q;
      tv_d = {tv_q[STAGES-1:0], wrap};
      gd_d = {gd_q[STAGES-1:0], wrap && int'(wu_q) == WARM};
      sh_d[0] = 8'(STAGES*(int'(k_q) + DIFF_DELAY - 1) - int'(g_q));
      for (int n = 1; n <= STAGES; n++) sh_d[n] = sh_q[n-1];
      int_d[0] = i_valid ? int_q[0] + {{(ACC_W-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data} : int_q[0];
      for (int n = 1; n < STAGES; n++) int_d[n] = i_valid ? int_q[n] + int_q[n-1] : int_q[n];
      cin[0] = int_q[STAGES-1];
      for (int n = 1; n < STAGES; n++) cin[n] = cb_q[n-1];
      for (int n = 0; n < STAGES; n++) begin
         cb_d[n] = tv_q[n] ? cin[n] - (DIFF_DELAY == 1 ? d1_q[n] : d2_q[n]) : cb_q[n];
         d1_d[n] = tv_q[n] ? cin[n] : d1_q[n];
         d2_d[n] = tv_q[n] ? d1_q[n] : d2_q[n];
      end
      xe = OUT_W'(signed'(cb_q[STAGES-1]));
      sh = sh_q[STAGES];
      y = (sh > 8'sd0) ? (xe + (ONE <<< (sh - 8'sd1))) >>> sh : xe <<< (-sh);
      sat = !((&y[OUT_W-1:DATA_WIDTH-1]) || !(|y[OUT_W-1:DATA_WIDTH-1]));
      o_valid_d = tv_q[STAGES] && gd_q[STAGES];
      o_data_d = !o_valid_d ? o_data_q :
                 sat ? {y[OUT_W-1], {(DATA_WIDTH-1){!y[OUT_W-1]}}} : y[DATA_WIDTH-1:0];
      o_sat_d = o_valid_d ? sat : o_sat_q;
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         int_q     <= '{default: '0};
         cb_q      <= '{default: '0};
         d1_q      <= '{default: '0};
         d2_q      <= '{default: '0};
         sh_q      <= '{default: '0};
         tv_q      <= '0;
         gd_q      <= '0;
         cnt_q     <= '0;
         k_q       <= '0;
         g_q       <= '0;
         wu_q      <= '0;
         started_q <= 1'b0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         o_sat_q   <= 1'b0;
      end else begin
         int_q     <= int_d;
         cb_q      <= cb_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         sh_q      <= sh_d;
         tv_q      <= tv_d;
         gd_q      <= gd_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         g_q       <= g_d;
         wu_q      <= wu_d;
         started_q <= started_d;
         o_data_q  <= o_data_d;
         o_valid_q <= o_valid_d;
         o_sat_q   <= o_sat_d;
      end
   end

   assign o_data  = o_data_q;
   assign o_valid = o_valid_q;
   assign o_sat   = o_sat_q;
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed vector table plus timing, rate-change, reset and ramp sequences
// for the default N=4, M=1, 16-bit configuration.
module tb_cic_decimator;
   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [15:0] din;
   logic               vld;
   logic [2:0]         rate, gain;
   logic signed [15:0] dout;
   logic               ov, osat;

   always #5 clk = ~clk;

   cic_decimator dut (
      .i_clk(clk), .i_resetn(rst_n), .i_data(din), .i_valid(vld),
      .i_rate_log2(rate), .i_gain_shift(gain),
      .o_data(dout), .o_valid(ov), .o_sat(osat)
   );

   int checks = 0, errors = 0, ecount = -1, xcount = 0;
   int se[$], sd[$], ss[$];

   typedef struct {
      logic [2:0] k;
      logic [2:0] g;
      int din;
      int exp_d;
      int exp_s;
      int first;
   } vec_t;
   vec_t vt[12];

   localparam int NS = 400;
   int     xs[NS];
   longint hh[29], tmp[29];
   int     expq[$];

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ecount++;
      if ($isunknown({dout, ov, osat})) xcount++;
      if (ov) begin
         se.push_back(ecount);
         sd.push_back(int'(dout));
         ss.push_back(int'(osat));
      end
   endtask

   task automatic release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ecount = -1;
      se.delete();
      sd.delete();
      ss.delete();
   endtask

   task automatic do_reset(input logic [2:0] k, input logic [2:0] g);
      rst_n = 1'b0;
      vld = 1'b0;
      din = '0;
      rate = k;
      gain = g;
      release_rst();
   endtask

   task automatic run_until(input int n, input int budget);
      while (se.size() < n && ecount < budget) step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int exp_e[7];
      int exp_p[3];
      int bad_hold, nsat;
      rst_n = 1'b1; vld = 1'b0; din = '0; rate = 3'd3; gain = 3'd0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_valid", ov, 0);
      check("reset_data", dout, 0);
      check("reset_sat", osat, 0);

      // k, g, input, settled output, sat, first strobe edge (5R-1 + 5)
      vt[0]  = '{3'd3, 3'd0, 1000, 1000, 0, 44};
      vt[1]  = '{3'd3, 3'd0, 32767, 32767, 0, 44};
      vt[2]  = '{3'd3, 3'd0, -32768, -32768, 0, 44};
      vt[3]  = '{3'd3, 3'd1, 20000, 32767, 1, 44};
      vt[4]  = '{3'd3, 3'd1, -20000, -32768, 1, 44};
      vt[5]  = '{3'd2, 3'd0, -1234, -1234, 0, 24};
      vt[6]  = '{3'd3, 3'd4, 100, 1600, 0, 44};
      vt[7]  = '{3'd1, 3'd7, 3, 384, 0, 14};
      vt[8]  = '{3'd0, 3'd0, 555, 555, 0, 14};
      vt[9]  = '{3'd7, 3'd0, 77, 77, 0, 324};
      vt[10] = '{3'd1, 3'd7, 300, 32767, 1, 14};
      vt[11] = '{3'd6, 3'd7, -1, -128, 0, 324};
      for (int i = 0; i < 12; i++) begin
         do_reset(vt[i].k, vt[i].g);
         din = 16'(vt[i].din);
         vld = 1'b1;
         run_until(4, 2000);
         check($sformatf("v%0d_nstrobe", i), se.size(), 4);
         if (se.size() >= 4) begin
            check($sformatf("v%0d_first_edge", i), se[0], vt[i].first);
            check($sformatf("v%0d_period", i), se[3] - se[2], (vt[i].first - 4) / 5);
            check($sformatf("v%0d_data", i), sd[3], vt[i].exp_d);
            check($sformatf("v%0d_sat", i), ss[3], vt[i].exp_s);
         end
      end

      // Timeline: warm-up, latency, then k 3->5 mid-period at count 4
      do_reset(3'd3, 3'd0);
      din = 16'sd1000;
      vld = 1'b1;
      bad_hold = 0;
      for (int e = 0; e <= 270; e++) begin
         step();
         if (ecount > 44 && dout != 16'sd1000) bad_hold++;
         if (ecount == 67) rate = 3'd5;
      end
      exp_e = '{44, 52, 60, 68, 76, 236, 268};
      check("tl_nstrobe", se.size(), 7);
      for (int i = 0; i < 7 && i < se.size(); i++) begin
         check($sformatf("tl_edge%0d", i), se[i], exp_e[i]);
         check($sformatf("tl_data%0d", i), sd[i], 1000);
      end
      check("tl_hold", bad_hold, 0);

      // Full-scale step: 32767 then -32768, 40 outputs each
      do_reset(3'd3, 3'd0);
      din = 16'sd32767;
      vld = 1'b1;
      run_until(40, 2000);
      check("fs_hi_n", se.size(), 40);
      if (se.size() >= 40) check("fs_hi_data", sd[39], 32767);
      din = -16'sd32768;
      run_until(80, 4000);
      check("fs_lo_n", se.size(), 80);
      if (se.size() >= 80) check("fs_lo_data", sd[79], -32768);
      nsat = 0;
      foreach (ss[i]) nsat += ss[i];
      check("fs_no_sat", nsat, 0);

      // Reset pulses: during a strobe, then two cycles after a decimating sample
      do_reset(3'd3, 3'd0);
      din = 16'sd1000;
      vld = 1'b1;
      while (ecount < 44) step();
      check("rp_strobe_before", ov, 1);
      rst_n = 1'b0;
      #1;
      check("rp_async_valid", ov, 0);
      check("rp_async_data", dout, 0);
      release_rst();
      while (ecount < 49) step();
      check("rp_data_before", dout, 1000);
      rst_n = 1'b0;
      #1;
      check("rp2_async_valid", ov, 0);
      check("rp2_async_data", dout, 0);
      check("rp2_async_sat", osat, 0);
      release_rst();
      while (ecount < 60) step();
      exp_p = '{44, 52, 60};
      check("rp_nstrobe", se.size(), 3);
      for (int i = 0; i < 3 && i < se.size(); i++) check($sformatf("rp_edge%0d", i), se[i], exp_p[i]);

      // Ramp reference: box^4 FIR with 3-sample integrator lag, round half up by 2^12
      for (int i = 0; i < NS; i++) begin
         logic signed [15:0] t16;
         t16 = 16'(32700 + i);
         xs[i] = int'(t16);
      end
      foreach (hh[j]) hh[j] = 0;
      hh[0] = 1;
      repeat (4) begin
         for (int j = 0; j < 29; j++) begin
            tmp[j] = 0;
            for (int m = 0; m < 8; m++) if (j - m >= 0) tmp[j] += hh[j-m];
         end
         hh = tmp;
      end
      for (int t = 5; t <= NS / 8; t++) begin
         longint acc, yv;
         acc = 0;
         for (int j = 0; j < 29; j++)
            if (8*t - 1 - 3 - j >= 0) acc += hh[j] * longint'(xs[8*t-1-3-j]);
         yv = (acc + 2048) >>> 12;
         yv = (yv > 32767) ? 32767 : (yv < -32768) ? -32768 : yv;
         expq.push_back(int'(yv));
      end

      for (int run = 0; run < 2; run++) begin
         do_reset(3'd3, 3'd0);
         for (int i = 0; i < NS; i++) begin
            din = 16'(xs[i]);
            vld = 1'b1;
            step();
            if (run == 1) begin
               vld = 1'b0;
               din = 16'($urandom);
               step();
               step();
            end
         end
         vld = 1'b0;
         repeat (10) step();
         check($sformatf("ramp%0d_n", run), se.size(), expq.size());
         for (int i = 0; i < expq.size() && i < sd.size(); i++)
            check($sformatf("ramp%0d_d%0d", run, i), sd[i], expq[i]);
      end
      check("no_x", xcount, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
